// File: rtl/pipe_mem_driver.sv
// Single-command-register memory driver with credit-limited in-order read responses.
// Request to mem command 1 cycle, read response C+READ_LATENCY+1; req_hold_o on mem stall or credits exhausted.
module pipe_mem_driver #(
  parameter int WIDTH        = 16,
  parameter int HEIGHT       = 16,
  parameter int READ_LATENCY = 1,
  parameter int DEPTH        = 4,
  localparam int ADDR        = $clog2(HEIGHT),
  localparam int SW          = WIDTH / 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_hold_o,
  input  logic             req_write_i,
  input  logic [ADDR-1:0]  req_addr_i,
  input  logic [WIDTH-1:0] req_data_i,
  input  logic [SW-1:0]    req_strb_i,
  output logic             rsp_valid_o,
  output logic [WIDTH-1:0] rsp_data_o,
  input  logic             rsp_hold_i,
  output logic             mem_enable_o,
  output logic             mem_write_o,
  output logic [ADDR-1:0]  mem_addr_o,
  output logic [WIDTH-1:0] mem_wrData_o,
  output logic [SW-1:0]    mem_strb_o,
  input  logic [WIDTH-1:0] mem_rdData_i,
  input  logic             mem_hold_i
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW:0] CREDIT_FULL = (CW + 1)'(DEPTH);

  logic             cmd_vld_q, cmd_vld_d;
  logic             cmd_wr_q, cmd_wr_d;
  logic [ADDR-1:0]  cmd_addr_q, cmd_addr_d;
  logic [WIDTH-1:0] cmd_data_q, cmd_data_d;
  logic [SW-1:0]    cmd_strb_q, cmd_strb_d;

  logic [READ_LATENCY-1:0] pipe_q;
  logic [WIDTH-1:0]        fifo_q [DEPTH];
  logic [PW-1:0]           rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]           cnt_q;
  logic [CW:0]             credit;

  logic accept, issue, push, pop, cmd_free;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign issue    = cmd_vld_q & ~mem_hold_i;
  assign cmd_free = ~cmd_vld_q | ~mem_hold_i;
  assign accept   = req_valid_i & ~req_hold_o;
  assign push     = pipe_q[READ_LATENCY-1];
  assign pop      = rsp_valid_o & ~rsp_hold_i;

  // Every read between acceptance and response pop holds one credit.
  always_comb begin
    credit = {1'b0, cnt_q} + {{CW{1'b0}}, cmd_vld_q & ~cmd_wr_q};
    for (int i = 0; i < READ_LATENCY; i++) begin
      credit = credit + {{CW{1'b0}}, pipe_q[i]};
    end
  end

  assign req_hold_o = ~rst_ni | (cmd_vld_q & mem_hold_i) | (credit == CREDIT_FULL);

  always_comb begin
    cmd_vld_d  = accept;
    cmd_wr_d   = accept & req_write_i;
    cmd_addr_d = accept ? req_addr_i : '0;
    cmd_data_d = (accept & req_write_i) ? req_data_i : '0;
    cmd_strb_d = (accept & req_write_i) ? req_strb_i : '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cmd_vld_q  <= 1'b0;
      cmd_wr_q   <= 1'b0;
      cmd_addr_q <= '0;
      cmd_data_q <= '0;
      cmd_strb_q <= '0;
    end else if (cmd_free) begin
      cmd_vld_q  <= cmd_vld_d;
      cmd_wr_q   <= cmd_wr_d;
      cmd_addr_q <= cmd_addr_d;
      cmd_data_q <= cmd_data_d;
      cmd_strb_q <= cmd_strb_d;
    end
  end

  assign mem_enable_o = cmd_vld_q;
  assign mem_write_o  = cmd_wr_q;
  assign mem_addr_o   = cmd_addr_q;
  assign mem_wrData_o = cmd_data_q;
  assign mem_strb_o   = cmd_strb_q;

  // The read pipe keeps shifting through memory stalls; issued reads always land.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pipe_q <= '0;
    end else begin
      pipe_q[0] <= issue & ~cmd_wr_q;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= mem_rdData_i;
        wr_ptr_q         <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      if (push && !pop) begin
        cnt_q <= cnt_q + CW'(1);
      end else if (!push && pop) begin
        cnt_q <= cnt_q - CW'(1);
      end
    end
  end

  assign rsp_valid_o = (cnt_q != '0);
  assign rsp_data_o  = fifo_q[rd_ptr_q];

  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push && !pop && cnt_q == CW'(DEPTH)));

endmodule

// File: tb/tb_pipe_mem_driver.sv
// Bench for pipe_mem_driver: directed scenarios plus randomized traffic against a memory/ordering model.
module tb_pipe_mem_driver;
  localparam int WIDTH  = 16;
  localparam int HEIGHT = 16;
  localparam int RL     = 2;
  localparam int DEPTH  = 4;
  localparam int ADDR   = 4;
  localparam int SW     = 2;

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b0;
  logic             req_valid_i = 1'b0, req_write_i = 1'b0;
  logic             req_hold_o;
  logic [ADDR-1:0]  req_addr_i = '0;
  logic [WIDTH-1:0] req_data_i = '0;
  logic [SW-1:0]    req_strb_i = '0;
  logic             rsp_valid_o, rsp_hold_i = 1'b0;
  logic [WIDTH-1:0] rsp_data_o;
  logic             mem_enable_o, mem_write_o, mem_hold_i = 1'b0;
  logic [ADDR-1:0]  mem_addr_o;
  logic [WIDTH-1:0] mem_wrData_o, mem_rdData_i;
  logic [SW-1:0]    mem_strb_o;

  pipe_mem_driver #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .READ_LATENCY(RL), .DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_hold_o(req_hold_o), .req_write_i(req_write_i),
    .req_addr_i(req_addr_i), .req_data_i(req_data_i), .req_strb_i(req_strb_i),
    .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o), .rsp_hold_i(rsp_hold_i),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
    .mem_wrData_o(mem_wrData_o), .mem_strb_o(mem_strb_o), .mem_rdData_i(mem_rdData_i),
    .mem_hold_i(mem_hold_i)
  );

  typedef struct packed {
    logic             w;
    logic [ADDR-1:0]  a;
    logic [WIDTH-1:0] d;
    logic [SW-1:0]    s;
  } cmd_t;

  cmd_t             cmdq[$];
  logic [WIDTH-1:0] expq[$];
  logic [WIDTH-1:0] ref_mem [HEIGHT];
  logic [WIDTH-1:0] mem_arr [HEIGHT];
  logic [WIDTH-1:0] rd_slot [8];
  int  checks = 0, failures = 0, out_rd = 0, cyc = 0;
  bit  rand_mode = 0;
  logic exp_en, exp_hold;

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: in-order driver, so a read returns memory as left by all earlier accepted writes.
  task automatic note_accept(input cmd_t c);
    cmd_t e;
    e = c;
    if (c.w) begin
      for (int b = 0; b < SW; b++)
        if (c.s[b]) ref_mem[c.a][8*b +: 8] = c.d[8*b +: 8];
    end else begin
      e.d = '0;
      e.s = '0;
      expq.push_back(ref_mem[c.a]);
      out_rd++;
    end
    cmdq.push_back(e);
  endtask

  // Memory with fixed read latency, standing in for the real RAM.
  initial begin
    for (int i = 0; i < HEIGHT; i++) begin
      mem_arr[i] = 16'h5A00 + 16'(i * 7);
      ref_mem[i] = 16'h5A00 + 16'(i * 7);
    end
    for (int i = 0; i < 8; i++) rd_slot[i] = 16'($urandom);
    mem_rdData_i = '0;
    forever begin
      @(negedge clk_i);
      mem_rdData_i = rd_slot[cyc % 8];
      rd_slot[cyc % 8] = 16'($urandom);
      if (rst_ni && mem_enable_o && !mem_hold_i) begin
        if (mem_write_o) begin
          for (int b = 0; b < SW; b++)
            if (mem_strb_o[b]) mem_arr[mem_addr_o][8*b +: 8] = mem_wrData_o[8*b +: 8];
        end else begin
          rd_slot[(cyc + RL) % 8] = mem_arr[mem_addr_o];
        end
      end
    end
  end

  // Monitor: checks handshakes, command fields and responses; pops the scoreboard.
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      chk("reset_outputs", {req_hold_o, mem_enable_o, mem_write_o, mem_addr_o, mem_wrData_o,
                            mem_strb_o, rsp_valid_o, rsp_data_o}, {1'b1, 41'd0});
      cmdq.delete();
      expq.delete();
      out_rd = 0;
    end else begin
      exp_en   = (cmdq.size() != 0);
      exp_hold = (exp_en && mem_hold_i) || (out_rd == DEPTH);
      chk("req_hold", req_hold_o, exp_hold);
      chk("mem_enable", mem_enable_o, exp_en);
      if (exp_en && mem_enable_o)
        chk("mem_cmd", {mem_write_o, mem_addr_o, mem_wrData_o, mem_strb_o}, cmdq[0]);
      if (rsp_valid_o) begin
        if (expq.size() == 0) chk("rsp_unexpected", rsp_valid_o, 0);
        else                  chk("rsp_data", rsp_data_o, expq[0]);
      end
      if (exp_en && !mem_hold_i) void'(cmdq.pop_front());
      if (rsp_valid_o && !rsp_hold_i && expq.size() != 0) begin
        void'(expq.pop_front());
        out_rd--;
      end
    end
  end

  task automatic send(input logic w, input logic [ADDR-1:0] a, input logic [WIDTH-1:0] d,
                      input logic [SW-1:0] s, output int acc_cyc);
    bit ok;
    ok = 0;
    acc_cyc = -1;
    req_valid_i = 1'b1; req_write_i = w; req_addr_i = a; req_data_i = d; req_strb_i = s;
    for (int t = 0; t < 60 && !ok; t++) begin
      @(negedge clk_i);
      if (!req_hold_o) begin
        ok = 1;
        acc_cyc = cyc;
      end
      @(posedge clk_i);
      if (ok) note_accept({w, a, (w ? d : 16'h0), (w ? s : 2'b00)});
      #1;
    end
    req_valid_i = 1'b0;
    if (!ok) chk("req_timeout", ok, 1);
  endtask

  task automatic drain();
    rand_mode = 0;
    mem_hold_i = 0; rsp_hold_i = 0; req_valid_i = 0;
    for (int t = 0; t < 80 && (expq.size() != 0 || cmdq.size() != 0); t++) begin
      @(posedge clk_i); #1;
    end
    @(posedge clk_i); #1;
    chk("drain_rsp_left", expq.size(), 0);
    chk("drain_cmd_left", cmdq.size(), 0);
  endtask

  initial begin
    forever begin
      @(posedge clk_i); #1;
      if (rand_mode) begin
        mem_hold_i = ($urandom_range(0, 3) == 0);
        rsp_hold_i = ($urandom_range(0, 2) == 0);
      end
    end
  end

  initial begin
    #400000;
    failures++;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, n;
    bit taken;
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    @(negedge clk_i);
    chk("first_cycle_ready", req_hold_o, 0);
    @(posedge clk_i); #1;

    // Write then read-back latency with READ_LATENCY=2: response visible 3 cycles after issue.
    send(1'b1, 4'd3, 16'hA5A5, 2'b11, acc);
    send(1'b0, 4'd3, 16'h0, 2'b00, acc);
    repeat (3) @(negedge clk_i);
    chk("lat_not_early", rsp_valid_o, 0);
    @(negedge clk_i);
    chk("lat_valid", rsp_valid_o, 1);
    chk("lat_data", rsp_data_o, 16'hA5A5);
    @(posedge clk_i); #1;
    drain();

    // Partial write then read: read command carries zero data and strobes.
    send(1'b1, 4'd2, 16'h12FF, 2'b01, acc);
    @(negedge clk_i);
    chk("pw_strb", mem_strb_o, 2'b01);
    chk("pw_data", mem_wrData_o, 16'h12FF);
    @(posedge clk_i); #1;
    send(1'b0, 4'd2, 16'hFFFF, 2'b11, acc);
    @(negedge clk_i);
    chk("rd_fields", {mem_write_o, mem_strb_o, mem_wrData_o}, 19'd0);
    @(posedge clk_i); #1;
    drain();

    // Back-to-back reads 0..7.
    for (int k = 0; k < 8; k++) send(1'b0, 4'(k), 16'h0, 2'b00, acc);
    drain();

    // Write to addr 5 stalled by memory for 3 cycles.
    send(1'b1, 4'd5, 16'hBEEF, 2'b10, acc);
    mem_hold_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) mem_hold_i = 1'b0;
      @(negedge clk_i);
      chk("hold_enable", mem_enable_o, 1);
      chk("hold_addr", mem_addr_o, 4'd5);
      chk("hold_req", req_hold_o, (k < 3));
      @(posedge clk_i); #1;
    end
    @(negedge clk_i);
    chk("hold_single_issue", mem_enable_o, 0);
    @(posedge clk_i); #1;
    drain();

    // Credit limit: 6 reads offered with responses stalled.
    rsp_hold_i = 1'b1;
    n = 0;
    req_valid_i = 1'b1; req_write_i = 1'b0; req_addr_i = '0; req_data_i = '0; req_strb_i = '0;
    for (int t = 0; t < 60 && n < 6; t++) begin
      @(negedge clk_i);
      taken = !req_hold_o;
      if (t == 20) begin
        chk("credit_accepted", n, 4);
        chk("credit_hold", req_hold_o, 1);
      end
      @(posedge clk_i);
      if (taken) begin
        note_accept({1'b0, 4'(n), 16'h0, 2'b00});
        n++;
      end
      #1;
      req_addr_i = 4'(n);
      if (t == 20) rsp_hold_i = 1'b0;
    end
    req_valid_i = 1'b0;
    chk("credit_all_taken", n, 6);
    drain();

    // Mid-operation reset with 2 reads in the pipe and 1 in the FIFO.
    rsp_hold_i = 1'b1;
    for (int k = 0; k < 3; k++) send(1'b0, 4'(k + 8), 16'h0, 2'b00, acc);
    @(posedge clk_i); #1;
    chk("pre_reset_fifo", rsp_valid_o, 1);
    rst_ni = 1'b0;
    #1;
    chk("async_reset", {req_hold_o, mem_enable_o, mem_write_o, mem_addr_o, mem_wrData_o,
                        mem_strb_o, rsp_valid_o, rsp_data_o}, {1'b1, 41'd0});
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("ready_after_reset", req_hold_o, 0);
    @(posedge clk_i); #1;
    rsp_hold_i = 1'b0;
    repeat (10) begin @(posedge clk_i); #1; end

    // Randomized traffic with random stalls on both sides.
    rand_mode = 1;
    repeat (250) begin
      send(($urandom_range(0, 9) < 4), 4'($urandom), 16'($urandom), 2'($urandom), acc);
      repeat ($urandom_range(0, 2)) begin @(posedge clk_i); #1; end
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
